// File: rtl/actbuf_arbiter_if.sv
// Activation buffer arbiter bus: ext load writes, compute reads, writeback
// enqueues, SRAM port and queue status. The slave modport is the arbiter's view.
interface actbuf_arbiter_if #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned WQ_DEPTH = 4
);
  logic                        ext_wr_valid;
  logic                        ext_wr_ready;
  logic [ADDR_W-1:0]           ext_wr_addr;
  logic [DATA_W-1:0]           ext_wr_data;

  logic                        int_rd_valid;
  logic                        int_rd_ready;
  logic [ADDR_W-1:0]           int_rd_addr;
  logic                        int_rd_data_valid;
  logic [DATA_W-1:0]           int_rd_data;

  logic                        int_wr_valid;
  logic                        int_wr_ready;
  logic [ADDR_W-1:0]           int_wr_addr;
  logic [DATA_W-1:0]           int_wr_data;

  logic                        sram_en;
  logic                        sram_wen;
  logic [ADDR_W-1:0]           sram_addr;
  logic [DATA_W-1:0]           sram_wdata;
  logic [DATA_W-1:0]           sram_rdata;

  logic                        wq_empty;
  logic [$clog2(WQ_DEPTH):0]   wq_count;

  modport slave (
    input  ext_wr_valid, ext_wr_addr, ext_wr_data,
    input  int_rd_valid, int_rd_addr,
    input  int_wr_valid, int_wr_addr, int_wr_data,
    input  sram_rdata,
    output ext_wr_ready, int_rd_ready, int_rd_data_valid, int_rd_data, int_wr_ready,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    output wq_empty, wq_count
  );

  modport master (
    output ext_wr_valid, ext_wr_addr, ext_wr_data,
    output int_rd_valid, int_rd_addr,
    output int_wr_valid, int_wr_addr, int_wr_data,
    output sram_rdata,
    input  ext_wr_ready, int_rd_ready, int_rd_data_valid, int_rd_data, int_wr_ready,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    input  wq_empty, wq_count
  );
endinterface

// File: rtl/actbuf_arbiter.sv
// Single-port activation SRAM arbiter with an in-order writeback queue.
// Priority: ext write > drain (queue full) > int read > drain (queue non-empty).
// Optional starvation guard: define ACTBUF_STARVE_GUARD_EN to let a long-waiting
// queue head outrank int reads for one cycle after STARVE_LIMIT blocked cycles.
module actbuf_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned WQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear,
  actbuf_arbiter_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(WQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {GntNone, GntExt, GntDrain, GntRead} gnt_e;

  logic [ADDR_W-1:0] q_addr_q [WQ_DEPTH];
  logic [DATA_W-1:0] q_data_q [WQ_DEPTH];
  logic [PtrW-1:0]   rptr_q, wptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              rd_pend_q;

  logic full, empty, hazard, starve_hit, enq, deq;
  gnt_e gnt;

  assign full  = (count_q == CntW'(WQ_DEPTH));
  assign empty = (count_q == '0);
  assign enq   = bus.int_wr_valid && !full;
  assign deq   = (gnt == GntDrain);

  // Read-after-write hazard: compare the read address against every live entry.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      if ((CntW'(i) < count_q) && (q_addr_q[rptr_q + PtrW'(i)] == bus.int_rd_addr)) begin
        hazard = 1'b1;
      end
    end
  end

`ifdef ACTBUF_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  logic [StW-1:0] starve_q, starve_d;

  assign starve_hit = !empty && (starve_q >= StW'(STARVE_LIMIT));

  // Count consecutive blocked cycles of a non-empty queue; any drain restarts it.
  always_comb begin
    starve_d = '0;
    if (deq) begin
      starve_d = '0;
    end else if (!empty) begin
      starve_d = (starve_q >= StW'(STARVE_LIMIT)) ? starve_q : starve_q + StW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_q <= '0;
    end else if (clear) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Guard disabled: the limit has no effect.
  assign starve_hit = 1'b0 & (STARVE_LIMIT == 0);
`endif

  // Fixed-priority grant; nothing is issued while a soft clear is in progress.
  always_comb begin
    gnt = GntNone;
    if (clear) begin
      gnt = GntNone;
    end else if (bus.ext_wr_valid) begin
      gnt = GntExt;
    end else if (full || starve_hit) begin
      gnt = GntDrain;
    end else if (bus.int_rd_valid && !hazard) begin
      gnt = GntRead;
    end else if (!empty) begin
      gnt = GntDrain;
    end
  end

  // Decode the grant into ready strobes and the SRAM bus; zero when idle.
  always_comb begin
    bus.ext_wr_ready = 1'b0;
    bus.int_rd_ready = 1'b0;
    bus.sram_en      = 1'b0;
    bus.sram_wen     = 1'b0;
    bus.sram_addr    = '0;
    bus.sram_wdata   = '0;
    unique case (gnt)
      GntExt: begin
        bus.ext_wr_ready = 1'b1;
        bus.sram_en      = 1'b1;
        bus.sram_wen     = 1'b1;
        bus.sram_addr    = bus.ext_wr_addr;
        bus.sram_wdata   = bus.ext_wr_data;
      end
      GntDrain: begin
        bus.sram_en    = 1'b1;
        bus.sram_wen   = 1'b1;
        bus.sram_addr  = q_addr_q[rptr_q];
        bus.sram_wdata = q_data_q[rptr_q];
      end
      GntRead: begin
        bus.int_rd_ready = 1'b1;
        bus.sram_en      = 1'b1;
        bus.sram_addr    = bus.int_rd_addr;
      end
      default: ;
    endcase
  end

  // Queue occupancy next state; simultaneous enq/deq leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage, pointers, occupancy and read-return flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else if (clear) begin
      // Queued writes are discarded; stale entries are masked by count_q.
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      if (enq) begin
        q_addr_q[wptr_q] <= bus.int_wr_addr;
        q_data_q[wptr_q] <= bus.int_wr_data;
        wptr_q           <= wptr_q + PtrW'(1);
      end
      if (deq) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q   <= count_d;
      rd_pend_q <= (gnt == GntRead);
    end
  end

  // A return landing in a clear cycle is dropped along with the rest of the state.
  assign bus.int_rd_data_valid = rd_pend_q & ~clear;
  assign bus.int_rd_data       = (rd_pend_q && !clear) ? bus.sram_rdata : '0;
  assign bus.int_wr_ready      = !full;
  assign bus.wq_empty          = empty;
  assign bus.wq_count          = count_q;

endmodule
